// File: rtl/mcalu.sv
`default_nettype none
// ============================================================================
// mcalu : multi-cycle ALU with valid/ready handshakes, shift-add multiplier and
//         optional restoring divider (compiled in when MCALU_DIV_EN is defined)
// Revision: 1.0
// ============================================================================
module mcalu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       status_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [7:0]       status_out,
  output logic             busy,
  output logic             err
);

  localparam int MSB   = WIDTH - 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SBC  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_INV  = 4'h8;
  localparam logic [3:0] OP_TWC  = 4'h9;
  localparam logic [3:0] OP_INC  = 4'hA;
  localparam logic [3:0] OP_DEC  = 4'hB;
  localparam logic [3:0] OP_LSL  = 4'hC;
  localparam logic [3:0] OP_LSR  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_DIV  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [1:0]       ti_q, ti_d;        // latched {I, T}
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [7:0]       status_q, status_d;
  logic             err_q, err_d;
`ifdef MCALU_DIV_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             unused_status;

  assign unused_status = ^{status_in[6:4], status_in[1:0]};
`endif

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_lo, alu_hi;
  logic             alu_c, alu_v, alu_err;
  logic [7:0]       alu_status;

  always_comb begin
    ext     = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_PASS: ext = {1'b0, a};
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        alu_c = ext[WIDTH];
        alu_v = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
      end
      OP_ADC: begin
        ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, status_in[2]};
        alu_c = ext[WIDTH];
        alu_v = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        ext   = {1'b0, a} - {1'b0, b};
        alu_c = ext[WIDTH];
        alu_v = (a[MSB] != b[MSB]) && (ext[MSB] != a[MSB]);
      end
      OP_SBC: begin
        ext   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, status_in[2]};
        alu_c = ext[WIDTH];
        alu_v = (a[MSB] != b[MSB]) && (ext[MSB] != a[MSB]);
      end
      OP_AND: ext = {1'b0, a & b};
      OP_OR:  ext = {1'b0, a | b};
      OP_XOR: ext = {1'b0, a ^ b};
      OP_INV: ext = {1'b0, ~a};
      OP_TWC: begin
        ext   = {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};
        alu_c = ext[WIDTH];
        alu_v = a[MSB] & ext[MSB];
      end
      OP_INC: begin
        ext   = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        alu_c = ext[WIDTH];
        alu_v = ~a[MSB] & ext[MSB];
      end
      OP_DEC: begin
        ext   = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
        alu_c = ext[WIDTH];
        alu_v = a[MSB] & ~ext[MSB];
      end
      OP_LSL: begin
        ext   = {1'b0, a[MSB-1:0], 1'b0};
        alu_c = a[MSB];
      end
      OP_LSR: begin
        ext   = {1'b0, status_in[2], a[MSB:1]};
        alu_c = a[0];
      end
      OP_DIV: begin
`ifdef MCALU_DIV_EN
        // Only reached with b == 0: saturated quotient, dividend as remainder.
        ext     = {1'b0, {WIDTH{1'b1}}};
        alu_hi  = a;
        alu_v   = 1'b1;
        alu_err = 1'b1;
`else
        ext     = {1'b0, a};
        alu_err = 1'b1;
`endif
      end
      default: ext = {1'b0, a};
    endcase
    alu_lo     = ext[MSB:0];
    alu_status = {status_in[7], 1'b1, alu_lo[MSB] ^ alu_v, alu_v,
                  status_in[3], alu_c, alu_lo[MSB], alu_lo == '0};
`ifndef MCALU_DIV_EN
    if (op == OP_DIV) begin
      alu_status = status_in | 8'h40;
    end
`endif
  end

  // One iteration of the multiplier (or divider) over the {acc_hi, acc_lo} pair.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_z, step_n, step_v;
  logic [7:0]       step_status;
`ifdef MCALU_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo_q[MSB:1]};
    step_z  = ({step_hi, step_lo} == '0);
    step_n  = step_hi[MSB];
    step_v  = (step_hi != '0);
`ifdef MCALU_DIV_EN
    div_shift = {acc_hi_q, acc_lo_q[MSB]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[MSB:0] - b_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[MSB:0];
      step_lo = {acc_lo_q[MSB-1:0], div_ge};
      step_z  = (step_lo == '0);
      step_n  = step_lo[MSB];
      step_v  = 1'b0;
    end
`endif
    step_status = {ti_q[1], 1'b1, step_n ^ step_v, step_v, ti_q[0], 1'b0, step_n, step_z};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    ti_d     = ti_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    status_d = status_q;
    err_d    = err_q;
`ifdef MCALU_DIV_EN
    b_d      = b_q;
    is_div_d = is_div_q;
`endif
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_d      = a;
            ti_d     = {status_in[7], status_in[3]};
            cnt_d    = '0;
            acc_hi_d = '0;
`ifdef MCALU_DIV_EN
            b_d      = b;
            is_div_d = (op == OP_DIV);
`endif
            if (op == OP_MUL) begin
              state_d  = BUSY;
              acc_lo_d = b;
            end
`ifdef MCALU_DIV_EN
            else if (op == OP_DIV && b != '0) begin
              state_d  = BUSY;
              acc_lo_d = a;
            end
`endif
            else begin
              state_d  = DONE;
              res_lo_d = alu_lo;
              res_hi_d = alu_hi;
              status_d = alu_status;
              err_d    = alu_err;
            end
          end
        end
        BUSY: begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            res_lo_d = step_lo;
            res_hi_d = step_hi;
            status_d = step_status;
            err_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      ti_q     <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      status_q <= 8'h40;
      err_q    <= 1'b0;
`ifdef MCALU_DIV_EN
      b_q      <= '0;
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      ti_q     <= ti_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      status_q <= status_d;
      err_q    <= err_d;
`ifdef MCALU_DIV_EN
      b_q      <= b_d;
      is_div_q <= is_div_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign res_lo     = res_lo_q;
  assign res_hi     = res_hi_q;
  assign status_out = status_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mcalu.sv
`default_nettype none
// ============================================================================
// tb_mcalu : randomized self-checking bench for mcalu against an arithmetic
//            reference model (honours MCALU_DIV_EN)
// Revision: 1.0
// ============================================================================
module tb_mcalu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [7:0]   status_in = '0;
  logic         in_ready, out_valid, busy, err;
  logic [W-1:0] res_lo, res_hi;
  logic [7:0]   status_out;

  int n_checks = 0;
  int n_pass   = 0;

  mcalu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .status_in(status_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_lo(res_lo), .res_hi(res_hi), .status_out(status_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic [7:0] st, output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic [7:0] so, output logic e, output int lat);
    longint m, ua, ub, sa, sb, r, t, p, cin;
    logic c, v, z, n;
    m   = longint'(1) << W;
    ua  = longint'(ma);
    ub  = longint'(mb);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sb  = (ub >= m / 2) ? ub - m : ub;
    cin = st[2] ? 1 : 0;
    r = 0; t = 0; c = 1'b0; hi = '0; e = 1'b0; lat = 1;
    case (mop)
      4'h0: r = ua;
      4'h1: begin r = ua + ub;       c = (r >= m); t = sa + sb;       end
      4'h2: begin r = ua + ub + cin; c = (r >= m); t = sa + sb + cin; end
      4'h3: begin r = ua - ub;       c = (r < 0);  t = sa - sb;       end
      4'h4: begin r = ua - ub - cin; c = (r < 0);  t = sa - sb - cin; end
      4'h5: r = ua & ub;
      4'h6: r = ua | ub;
      4'h7: r = ua ^ ub;
      4'h8: r = m - 1 - ua;
      4'h9: begin r = -ua;    c = (ua == 0); t = -sa;    end
      4'hA: begin r = ua + 1; c = (r >= m);  t = sa + 1; end
      4'hB: begin r = ua - 1; c = (r < 0);   t = sa - 1; end
      4'hC: begin r = ua * 2; c = (ua >= m / 2); end
      4'hD: begin r = ua / 2 + cin * (m / 2); c = (ua % 2 == 1); end
      default: r = 0;
    endcase
    v  = (t < -(m / 2)) || (t >= m / 2);
    lo = r[W-1:0];
    z  = (lo == 0);
    n  = lo[W-1];
    if (mop == 4'hE) begin
      p   = ua * ub;
      lo  = p[W-1:0];
      hi  = p[2*W-1:W];
      z   = (p == 0);
      n   = p[2*W-1];
      v   = (hi != 0);
      c   = 1'b0;
      lat = W + 1;
    end else if (mop == 4'hF) begin
`ifdef MCALU_DIV_EN
      c = 1'b0;
      if (ub == 0) begin
        lo = '1; hi = ma; v = 1'b1; e = 1'b1; z = 1'b0; n = 1'b1;
      end else begin
        r   = ua / ub;
        p   = ua % ub;
        lo  = r[W-1:0];
        hi  = p[W-1:0];
        z   = (lo == 0);
        n   = lo[W-1];
        v   = 1'b0;
        lat = W + 1;
      end
`else
      lo = ma; hi = '0; e = 1'b1;
      so = st | 8'h40;
      return;
`endif
    end
    so = {st[7], 1'b1, n ^ v, v, st[3], c, n, z};
  endfunction

  // Drive one operation and return after the accept edge; inputs are then scrambled.
  task automatic issue(input logic [3:0] iop, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [7:0] ist);
    op = iop; a = ia; b = ib; status_in = ist; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom); status_in = 8'($urandom);
  endtask

  task automatic wait_out(output int lat, output bit busy_all);
    lat = 1;
    busy_all = 1'b1;
    while (!out_valid && lat < 100) begin
      busy_all &= busy;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    logic [2*W+11:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {in_ready, out_valid, busy, err, res_lo, res_hi, status_out};
    n_checks++;
    if (got !== {4'b1000, {(2*W){1'b0}}, 8'h40})
      $display("FAIL reset_state: got %h want %h", got, {4'b1000, {(2*W){1'b0}}, 8'h40});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat; bit ba;
    // ADD with signed overflow
    issue(4'h1, 16'h7FFF, 16'h0001, 8'h00);
    wait_out(lat, ba);
    n_checks++;
    if ({res_lo, res_hi, status_out, err, lat[7:0]} !== {16'h8000, 16'h0000, 8'h52, 1'b0, 8'd1})
      $display("FAIL add_ovf: got lo=%h hi=%h st=%h err=%b lat=%0d want 8000 0000 52 0 1", res_lo, res_hi, status_out, err, lat);
    else n_pass++;
    release_out();
    // MUL of all ones
    issue(4'hE, 16'hFFFF, 16'hFFFF, 8'h00);
    wait_out(lat, ba);
    n_checks++;
    if ({res_hi, res_lo, status_out, err, lat[7:0], ba} !== {16'hFFFE, 16'h0001, 8'h52, 1'b0, 8'd17, 1'b1})
      $display("FAIL mul_max: got hi=%h lo=%h st=%h err=%b lat=%0d busy=%b want FFFE 0001 52 0 17 1", res_hi, res_lo, status_out, err, lat, ba);
    else n_pass++;
    release_out();
    // LSR shifts carry into MSB
    issue(4'hD, 16'h0002, 16'h0000, 8'h04);
    wait_out(lat, ba);
    n_checks++;
    if ({res_lo, status_out} !== {16'h8001, 8'h62})
      $display("FAIL lsr_carry: got lo=%h st=%h want 8001 62", res_lo, status_out);
    else n_pass++;
    release_out();
    // ADC wraps to zero with carry
    issue(4'h2, 16'hFFFF, 16'h0000, 8'h04);
    wait_out(lat, ba);
    n_checks++;
    if ({res_lo, status_out} !== {16'h0000, 8'h45})
      $display("FAIL adc_wrap: got lo=%h st=%h want 0000 45", res_lo, status_out);
    else n_pass++;
    release_out();
`ifdef MCALU_DIV_EN
    issue(4'hF, 16'd100, 16'd7, 8'h00);
    wait_out(lat, ba);
    n_checks++;
    if ({res_lo, res_hi, status_out, err, lat[7:0]} !== {16'd14, 16'd2, 8'h40, 1'b0, 8'd17})
      $display("FAIL div_100_7: got lo=%h hi=%h st=%h err=%b lat=%0d want 000e 0002 40 0 17", res_lo, res_hi, status_out, err, lat);
    else n_pass++;
    release_out();
    issue(4'hF, 16'd5, 16'd0, 8'h00);
    wait_out(lat, ba);
    n_checks++;
    if ({res_lo, res_hi, status_out, err, lat[7:0]} !== {16'hFFFF, 16'd5, 8'h52, 1'b1, 8'd1})
      $display("FAIL div_zero: got lo=%h hi=%h st=%h err=%b lat=%0d want ffff 0005 52 1 1", res_lo, res_hi, status_out, err, lat);
    else n_pass++;
    release_out();
`else
    issue(4'hF, 16'h1234, 16'h0055, 8'h8C);
    wait_out(lat, ba);
    n_checks++;
    if ({res_lo, res_hi, status_out, err, lat[7:0]} !== {16'h1234, 16'h0000, 8'hCC, 1'b1, 8'd1})
      $display("FAIL div_disabled: got lo=%h hi=%h st=%h err=%b lat=%0d want 1234 0000 cc 1 1", res_lo, res_hi, status_out, err, lat);
    else n_pass++;
    release_out();
`endif
  endtask

  task automatic test_random();
    logic [3:0] rop; logic [W-1:0] ra, rb, elo, ehi; logic [7:0] rst, eso; logic ee;
    int elat, lat; bit ba;
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom); ra = pick_operand(); rb = pick_operand(); rst = 8'($urandom);
      model(rop, ra, rb, rst, elo, ehi, eso, ee, elat);
      issue(rop, ra, rb, rst);
      wait_out(lat, ba);
      n_checks++;
      if ({res_lo, res_hi, status_out, err} !== {elo, ehi, eso, ee})
        $display("FAIL rand_result op=%h a=%h b=%h st=%h: got %h %h %h %b want %h %h %h %b",
                 rop, ra, rb, rst, res_lo, res_hi, status_out, err, elo, ehi, eso, ee);
      else n_pass++;
      n_checks++;
      if (lat != elat) $display("FAIL rand_latency op=%h: got %0d want %0d", rop, lat, elat);
      else n_pass++;
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit ba;
    issue(4'h3, 16'd3, 16'd5, 8'h00);
    wait_out(lat, ba);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({res_lo, res_hi, status_out, err, out_valid, in_ready} !== {16'hFFFE, 16'h0000, 8'h66, 1'b0, 1'b1, 1'b0})
        $display("FAIL backpressure_hold cycle %0d: got lo=%h hi=%h st=%h err=%b ov=%b ir=%b want fffe 0000 66 0 1 0",
                 i, res_lo, res_hi, status_out, err, out_valid, in_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    release_out();
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL backpressure_release: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit seen; int lat; bit ba;
    logic [W-1:0] ra, rb, elo, ehi; logic [7:0] eso; logic ee; int elat;
    issue(4'hE, 16'hFFFF, 16'hFFFF, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL flush_busy: got ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL flush_no_result: got out_valid seen=%b want 0", seen);
    else n_pass++;
    // flush coinciding with an accept cancels it
    op = 4'h1; a = 16'h0001; b = 16'h0002; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL flush_accept: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    else n_pass++;
    ra = W'($urandom); rb = W'($urandom);
    model(4'h3, ra, rb, 8'h00, elo, ehi, eso, ee, elat);
    issue(4'h3, ra, rb, 8'h00);
    wait_out(lat, ba);
    n_checks++;
    if ({res_lo, res_hi, status_out, err, lat[7:0]} !== {elo, ehi, eso, ee, elat[7:0]})
      $display("FAIL flush_recover: got %h %h %h %b lat=%0d want %h %h %h %b lat=%0d",
               res_lo, res_hi, status_out, err, lat, elo, ehi, eso, ee, elat);
    else n_pass++;
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [2*W+11:0] got;
`ifdef MCALU_DIV_EN
    issue(4'hF, 16'd100, 16'd7, 8'h00);
`else
    issue(4'hE, 16'h1234, 16'h5678, 8'h00);
`endif
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = {in_ready, out_valid, busy, err, res_lo, res_hi, status_out};
    n_checks++;
    if (got !== {4'b1000, {(2*W){1'b0}}, 8'h40})
      $display("FAIL reset_mid_op: got %h want %h", got, {4'b1000, {(2*W){1'b0}}, 8'h40});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (W + 2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL reset_mid_idle: got ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] rop; logic [W-1:0] ra, rb, elo, ehi; logic [7:0] rst, eso; logic ee; int elat;
    out_ready = 1'b1;
    rop = 4'($urandom_range(0, 13)); ra = pick_operand(); rb = pick_operand(); rst = 8'($urandom);
    op = rop; a = ra; b = rb; status_in = rst; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      model(rop, ra, rb, rst, elo, ehi, eso, ee, elat);
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, res_lo, res_hi, status_out, err} !== {1'b1, elo, ehi, eso, ee})
        $display("FAIL b2b_result %0d op=%h: got ov=%b %h %h %h %b want 1 %h %h %h %b",
                 i, rop, out_valid, res_lo, res_hi, status_out, err, elo, ehi, eso, ee);
      else n_pass++;
      rop = 4'($urandom_range(0, 13)); ra = pick_operand(); rb = pick_operand(); rst = 8'($urandom);
      op = rop; a = ra; b = rb; status_in = rst;
      @(posedge clk); #1;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL b2b_ready %0d: got ir=%b ov=%b want 1 0", i, in_ready, out_valid);
      else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mcalu.md
# mcalu

Parametrised, multi-cycle successor to the CPU's combinational 16-bit ALU. Adds operand width as a parameter, valid/ready handshakes on both sides, and an iterative shift-add multiplier in place of the separate array multiplier. Adds an optional iterative restoring divider and registered status-flag generation. Sits between operand fetch and writeback; the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 16: operand/result width; legal values are 4 to 32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous abort; discards any accepted operation.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: high only in IDLE.
- `op` in 4: opcode.
  - 0 PASS, 1 ADD, 2 ADC, 3 SUB, 4 SBC, 5 AND, 6 OR, 7 XOR.
  - 8 INV, 9 TWC, A INC, B DEC, C LSL, D LSR, E MUL, F DIV.
- `a`, `b` in WIDTH: operands.
- `status_in` in 8: current status register. Bit layout: [0]Z [1]N [2]C [3]T [4]V [5]S [6]=1 [7]I.
- `out_valid` out 1: result held valid.
- `out_ready` in 1: consumer accepts.
- `res_lo` out WIDTH: result, low product, or quotient.
- `res_hi` out WIDTH: high product or remainder; 0 for other ops.
- `status_out` out 8: updated status.
- `busy` out 1: state ≠ IDLE.
- `err` out 1: divide-by-zero, or DIV when the divider is compiled out.

## Operation
- FSM states are IDLE, BUSY and DONE.
- IDLE → accept on `in_valid & in_ready`. Latch `op`, `a`, `b` and `status_in`; later input changes are ignored.
- Single-cycle ops (0–D, DIV with b=0, DIV when disabled): IDLE → DONE with the result registered.
- MUL/DIV: IDLE → BUSY, with a WIDTH-step counter → DONE.
- DONE holds every output stable until `out_ready`, then goes to IDLE.
- `flush` (any state) → IDLE next edge, `out_valid`=0, result dropped. `flush` in the same cycle as an accept: the accept is cancelled.
- Arithmetic is computed in WIDTH+1 bits; bit WIDTH is the carry.
  - ADD: C = carry out.
  - ADC: C = carry out, with carry-in = latched C.
  - SUB: a−b; C=1 on borrow.
  - SBC: a−b−C.
  - INC/DEC: ±1, with C = carry/borrow.
  - TWC: ~a+1.
  - LSL: C = a[W−1], 0 shifted in.
  - LSR: C = a[0], latched C shifted into the MSB.
- V is signed overflow for ADD/ADC/SUB/SBC/INC/DEC/TWC; it is 0 for logic ops and shifts.
- MUL is unsigned shift-add, one partial product per cycle: {res_hi,res_lo} = a*b.
  - Z = product==0.
  - N = product[2W−1].
  - C = 0.
  - V = res_hi≠0.
- DIV is unsigned restoring, one quotient bit per cycle: res_lo = a/b, res_hi = a%b.
  - Z = quotient==0.
  - N = quotient MSB.
  - C = 0.
  - V = 0.
- DIV with b=0 completes in a single cycle: res_lo = all ones, res_hi = a, V=1, `err`=1.
- For all ops except MUL and DIV: Z = res_lo==0 and N = res_lo[W−1].
- S = N^V always. Bit 6 = 1. T and I pass through from the latched `status_in`.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=1 (combinational from state).
  - `out_valid`=0, `busy`=0, `err`=0.
  - `res_lo`=`res_hi`=0.
  - `status_out`=8'h40.
- Single-cycle op accepted at edge N: `out_valid` is high after edge N+1 (latency 1).
- MUL/DIV accepted at edge N: `out_valid` is high after edge N+WIDTH+1.
- Handshake rules:
  - `out_valid` does not wait on `out_ready`.
  - The output transfer happens on the edge where both are high.
  - `in_ready` rises the cycle after the transfer.
  - Maximum throughput is one op per 2 cycles.
- `rst_n` asserted mid-operation: all outputs return to their reset values immediately; no partial result appears.
- The counter never wraps: BUSY exits exactly when the counter reaches WIDTH−1.

## Configuration
- `MCALU_DIV_EN` defined: the divider datapath and the DIV path are compiled in.
- `MCALU_DIV_EN` undefined: no divider logic. Op F completes in a single cycle with res_lo = a, res_hi = 0, `status_out` = latched `status_in` | 8'h40, and `err`=1.

## Test plan
- ADD: a=16'h7FFF, b=16'h0001, status_in=8'h00 → res_lo=16'h8000, status_out=8'h52 (N,V set; S=0), `out_valid` 1 cycle after accept.
- MUL: a=b=16'hFFFF → res_hi=16'hFFFE, res_lo=16'h0001, V=1, `out_valid` 17 cycles after accept, `busy` high throughout.
- DIV (`MCALU_DIV_EN`): a=100, b=7 → res_lo=14, res_hi=2, after 17 cycles. a=5, b=0 → res_lo=16'hFFFF, res_hi=5, V=1, err=1, 1 cycle. Rebuild without the macro: op F → res_lo=a, err=1.
- Backpressure: SUB 3−5 with `out_ready` held low for 5 cycles → res_lo=16'hFFFE with C=1, outputs stable and `in_ready`=0 throughout, IDLE one cycle after `out_ready` is raised.
- Flush/reset: MUL started and `flush` pulsed at the 5th BUSY cycle → no `out_valid`, `in_ready`=1 next cycle. `rst_n` pulsed mid-DIV → all outputs at reset values asynchronously.
- LSR/ADC chain: status_in C=1, LSR a=16'h0002 → res_lo=16'h8001, C=0. ADC 16'hFFFF+0 with C=1 → res_lo=0, Z=1, C=1.
